mem_port_arbiter: RTL and testbench

Shares one AHB-style memory port between the Cache's instruction fetch side (ITrans/InstAdress) and data side (DTrans/DataAdress/DPReadWrite/DPWriteBus). Data accesses have priority, and a streak counter guarantees instruction fetches cannot starve. A watchdog completes hung transfers with an error. The block sits between Cache and the single ROM/RAM slave.

---
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction and data masters
// Data wins arbitration, a streak limit bounds instruction starvation, and a watchdog ends hung transfers.
module mem_port_arbiter #(
  parameter int WIDTH          = 16,
  parameter int MAX_DATA_BURST = 4,
  parameter int TIMEOUT        = 255
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             ITrans,
  input  logic [WIDTH-1:0] IAdress,
  output logic             IReady,
  output logic [WIDTH-1:0] IReadBus,
  output logic             IErr,
  input  logic             DTrans,
  input  logic [WIDTH-1:0] DAdress,
  input  logic             DReadWrite,
  input  logic [WIDTH-1:0] DWriteBus,
  output logic             DReady,
  output logic [WIDTH-1:0] DReadBus,
  output logic             DErr,
  output logic             MTrans,
  output logic [WIDTH-1:0] MAdress,
  output logic             MReadWrite,
  output logic [WIDTH-1:0] MWriteBus,
  input  logic [WIDTH-1:0] MReadBus,
  input  logic             MReady,
  output logic [1:0]       Owner,
  output logic             Busy
);

  localparam int StreakW = (MAX_DATA_BURST > 0) ? $clog2(MAX_DATA_BURST + 1) : 1;
  localparam int WaitW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_DATA_BURST);
  localparam logic [WaitW-1:0]   WaitLast  = WaitW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // Encoding doubles as the Owner code.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    I_BUSY = 2'b01,
    D_BUSY = 2'b10
  } state_t;

  state_t             state, nextState;
  logic [StreakW-1:0] DStreak, nextStreak;
  logic [WaitW-1:0]   WaitCnt, nextWait;
  logic               inBusy;
  logic               timedOut;
  logic               done;

  assign inBusy   = (state != IDLE);
  assign timedOut = (TIMEOUT != 0) && inBusy && !MReady && (WaitCnt == WaitLast);
  assign done     = inBusy && (MReady || timedOut);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state   <= IDLE;
      DStreak <= '0;
      WaitCnt <= '0;
    end else begin
      state   <= nextState;
      DStreak <= nextStreak;
      WaitCnt <= nextWait;
    end
  end

  always_comb begin
    nextState  = state;
    nextStreak = DStreak;
    nextWait   = WaitCnt;
    case (state)
      IDLE: begin
        // The streak only grows while an instruction fetch is being passed over.
        if (DTrans && (!ITrans || (DStreak < StreakMax))) begin
          nextState  = D_BUSY;
          nextStreak = ITrans ? DStreak + 1'b1 : '0;
          nextWait   = '0;
        end else if (ITrans) begin
          nextState  = I_BUSY;
          nextStreak = '0;
          nextWait   = '0;
        end
      end
      I_BUSY, D_BUSY: begin
        if (done) begin
          nextState = IDLE;
        end else begin
          nextWait = WaitCnt + 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    MTrans     = 1'b0;
    MAdress    = '0;
    MReadWrite = 1'b0;
    MWriteBus  = '0;
    IReady     = 1'b0;
    IErr       = 1'b0;
    IReadBus   = '0;
    DReady     = 1'b0;
    DErr       = 1'b0;
    DReadBus   = '0;
    case (state)
      I_BUSY: begin
        MTrans   = 1'b1;
        MAdress  = IAdress;
        IReady   = done;
        IErr     = timedOut;
        IReadBus = MReady ? MReadBus : '0;
      end
      D_BUSY: begin
        MTrans     = 1'b1;
        MAdress    = DAdress;
        MReadWrite = DReadWrite;
        MWriteBus  = DWriteBus;
        DReady     = done;
        DErr       = timedOut;
        DReadBus   = MReady ? MReadBus : '0;
      end
      default: ;
    endcase
  end

  assign Owner = state;
  assign Busy  = inBusy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized bench for mem_port_arbiter
// A memory slave with programmable wait states sits behind the port; a transaction-level model predicts grants and data.
module tb_mem_port_arbiter;
  localparam int W    = 16;
  localparam int MAXB = 4;
  localparam int TO   = 8;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         ITrans = 1'b0;
  logic [W-1:0] IAdress = '0;
  logic         IReady;
  logic [W-1:0] IReadBus;
  logic         IErr;
  logic         DTrans = 1'b0;
  logic [W-1:0] DAdress = '0;
  logic         DReadWrite = 1'b0;
  logic [W-1:0] DWriteBus = '0;
  logic         DReady;
  logic [W-1:0] DReadBus;
  logic         DErr;
  logic         MTrans;
  logic [W-1:0] MAdress;
  logic         MReadWrite;
  logic [W-1:0] MWriteBus;
  logic [W-1:0] MReadBus;
  logic         MReady;
  logic [1:0]   Owner;
  logic         Busy;

  mem_port_arbiter #(.WIDTH(W), .MAX_DATA_BURST(MAXB), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst(Rst),
    .ITrans(ITrans), .IAdress(IAdress), .IReady(IReady), .IReadBus(IReadBus), .IErr(IErr),
    .DTrans(DTrans), .DAdress(DAdress), .DReadWrite(DReadWrite), .DWriteBus(DWriteBus),
    .DReady(DReady), .DReadBus(DReadBus), .DErr(DErr),
    .MTrans(MTrans), .MAdress(MAdress), .MReadWrite(MReadWrite), .MWriteBus(MWriteBus),
    .MReadBus(MReadBus), .MReady(MReady), .Owner(Owner), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Slave: answers after waitCfg wait states, or never while tie0 is set.
  logic [W-1:0] mem    [0:63];
  logic [W-1:0] refMem [0:63];
  int   waitCfg   = 0;
  int   slvCnt    = 0;
  logic tie0      = 1'b0;
  logic idlePulse = 1'b0;

  assign MReady   = !tie0 && ((MTrans && (slvCnt == waitCfg)) || idlePulse);
  assign MReadBus = mem[MAdress[5:0]];

  always @(posedge Clk) begin
    if (!MTrans || MReady) slvCnt <= 0;
    else                   slvCnt <= slvCnt + 1;
    if (MTrans && MReady && MReadWrite) mem[MAdress[5:0]] <= MWriteBus;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    @(posedge Clk);
    #1;
  endtask

  task automatic samp();
    @(negedge Clk);
  endtask

  function automatic logic [W-1:0] romWord(input int i);
    return W'(32'hC000 + i * 37);
  endfunction

  int         mtCnt, irCnt, drCnt, busyN, readyAt, grants, age, streak;
  logic       okFlag, capErr, justReady, rdy, iDone, dDone, quiet;
  logic [W-1:0] capData;
  logic [1:0] prevOwn, capOwn, expOwn;
  string      order;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]    = romWord(i);
      refMem[i] = romWord(i);
    end

    // Reset state
    samp();
    chk("reset_ctrl", 32'({MTrans, Busy, Owner, IReady, DReady, IErr, DErr, MReadWrite}), 32'd0);
    chk("reset_madr", 32'(MAdress), 32'd0);
    chk("reset_rbus", 32'({IReadBus, DReadBus}), 32'd0);
    drive();
    Rst = 1'b1;

    // Instruction fetch with one wait state
    waitCfg = 1;
    drive();
    ITrans = 1'b1; IAdress = 16'h0010;
    mtCnt = 0; irCnt = 0; drCnt = 0; okFlag = 1'b1; capData = '0;
    for (int c = 0; c < 6; c++) begin
      samp();
      if (MTrans) begin
        mtCnt++;
        if (MAdress !== 16'h0010 || MReadWrite !== 1'b0 || MWriteBus !== '0 || Owner !== 2'b01) okFlag = 1'b0;
      end
      if (IReady) begin irCnt++; capData = IReadBus; end
      if (DReady) drCnt++;
      drive();
      if (irCnt > 0) ITrans = 1'b0;
    end
    chk("ifetch_mtrans_cycles", 32'(mtCnt), 32'd2);
    chk("ifetch_bus", 32'(okFlag), 32'd1);
    chk("ifetch_ready_pulses", 32'(irCnt), 32'd1);
    chk("ifetch_data", 32'(capData), 32'(romWord(16)));
    chk("ifetch_no_dready", 32'(drCnt), 32'd0);

    // Data write
    waitCfg = 0;
    DTrans = 1'b1; DAdress = 16'h0003; DWriteBus = 16'h0004; DReadWrite = 1'b1;
    mtCnt = 0; irCnt = 0; drCnt = 0; okFlag = 1'b1;
    for (int c = 0; c < 5; c++) begin
      samp();
      if (MTrans) begin
        mtCnt++;
        if (MReadWrite !== 1'b1 || MWriteBus !== 16'h0004 || MAdress !== 16'h0003 || Owner !== 2'b10) okFlag = 1'b0;
      end
      if (DReady) drCnt++;
      if (IReady) irCnt++;
      drive();
      if (drCnt > 0) DTrans = 1'b0;
    end
    refMem[3] = 16'h0004;
    chk("dwrite_bus", 32'(okFlag), 32'd1);
    chk("dwrite_ready_pulses", 32'(drCnt), 32'd1);
    chk("dwrite_mtrans_cycles", 32'(mtCnt), 32'd1);
    chk("dwrite_ram3", 32'(mem[3]), 32'h4);
    chk("dwrite_no_iready", 32'(irCnt), 32'd0);

    // Both masters held continuously from a fresh reset
    Rst = 1'b0;
    drive();
    Rst = 1'b1;
    ITrans = 1'b1; IAdress = 16'h0007;
    DTrans = 1'b1; DAdress = 16'h0005; DReadWrite = 1'b0;
    order = ""; prevOwn = 2'b00; grants = 0;
    for (int c = 0; c < 24; c++) begin
      samp();
      if (prevOwn == 2'b00 && Owner != 2'b00 && grants < 10) begin
        if (Owner == 2'b01) order = {order, "I"};
        else                order = {order, "D"};
        grants++;
      end
      prevOwn = Owner;
      drive();
    end
    checks++;
    assert (order == "DDDDIDDDDI") else begin
      errors++;
      $error("FAIL grant_order: observed %s expected DDDDIDDDDI", order);
    end
    ITrans = 1'b0; DTrans = 1'b0;
    for (int c = 0; c < 3; c++) drive();

    // Watchdog on a slave that never answers
    tie0 = 1'b1;
    DTrans = 1'b1; DReadWrite = 1'b0; DAdress = 16'h0009;
    busyN = 0; drCnt = 0; readyAt = 0; justReady = 1'b0; capOwn = 2'b11; capErr = 1'b0; capData = 16'hFFFF;
    for (int c = 0; c < 14; c++) begin
      samp();
      if (justReady) begin capOwn = Owner; justReady = 1'b0; end
      if (Busy) busyN++;
      if (DReady) begin drCnt++; readyAt = busyN; capErr = DErr; capData = DReadBus; justReady = 1'b1; end
      drive();
      if (drCnt > 0) DTrans = 1'b0;
    end
    chk("timeout_ready_cycle", 32'(readyAt), 32'd8);
    chk("timeout_err", 32'(capErr), 32'd1);
    chk("timeout_data", 32'(capData), 32'd0);
    chk("timeout_ready_pulses", 32'(drCnt), 32'd1);
    chk("timeout_then_idle", 32'(capOwn), 32'd0);
    chk("timeout_busy_cycles", 32'(busyN), 32'd8);

    // Asynchronous reset in the middle of a data transfer
    DTrans = 1'b1; DAdress = 16'h0002;
    samp(); drive(); samp(); drive(); samp();
    chk("rst_pre_busy", 32'({Busy, Owner}), 32'b110);
    #2;
    Rst = 1'b0;
    #1;
    chk("rst_async_ctrl", 32'({MTrans, Busy, Owner}), 32'd0);
    ITrans = 1'b1; IAdress = 16'h0021; DTrans = 1'b0; tie0 = 1'b0; waitCfg = 0;
    drive();
    Rst = 1'b1;
    samp();
    chk("rst_release_idle", 32'(Owner), 32'd0);
    drive();
    samp();
    chk("rst_igrant_owner", 32'(Owner), 32'd1);
    chk("rst_igrant_ready", 32'(IReady), 32'd1);
    chk("rst_igrant_data", 32'(IReadBus), 32'(refMem[33]));
    drive();
    ITrans = 1'b0;

    // MReady while idle
    drive();
    idlePulse = 1'b1;
    samp();
    chk("idle_mready_quiet", 32'({IReady, DReady, IErr, DErr}), 32'd0);
    chk("idle_mready_rbus", 32'({IReadBus, DReadBus}), 32'd0);
    chk("idle_mready_owner", 32'({Busy, Owner}), 32'd0);
    drive();
    idlePulse = 1'b0;
    samp();
    chk("idle_mready_stays_idle", 32'({Busy, Owner}), 32'd0);

    // Randomized traffic against the transaction model
    drive();
    Rst = 1'b0;
    drive();
    Rst = 1'b1;
    expOwn = 2'b00; age = 0; streak = 0;
    for (int r = 0; r < 3; r++) begin
      waitCfg = (r == 0) ? 0 : ((r == 1) ? 1 : 3);
      for (int c = 0; c < 160; c++) begin
        samp();
        iDone = 1'b0; dDone = 1'b0;
        chk("rnd_owner", 32'(Owner), 32'(expOwn));
        if (expOwn != 2'b00) begin
          rdy = (age == waitCfg);
          chk("rnd_iready", 32'(IReady), 32'(expOwn == 2'b01 && rdy));
          chk("rnd_dready", 32'(DReady), 32'(expOwn == 2'b10 && rdy));
          chk("rnd_err", 32'({IErr, DErr}), 32'd0);
          if (rdy) begin
            if (expOwn == 2'b01) begin
              chk("rnd_idata", 32'(IReadBus), 32'(refMem[IAdress[5:0]]));
              iDone = 1'b1;
            end else begin
              if (DReadWrite) refMem[DAdress[5:0]] = DWriteBus;
              else chk("rnd_ddata", 32'(DReadBus), 32'(refMem[DAdress[5:0]]));
              dDone = 1'b1;
            end
            expOwn = 2'b00;
            age = 0;
          end else begin
            age++;
          end
        end else begin
          chk("rnd_idle_quiet", 32'({IReady, DReady, IErr, DErr}), 32'd0);
          if (DTrans && (!ITrans || streak < MAXB)) begin
            expOwn = 2'b10;
            streak = ITrans ? streak + 1 : 0;
          end else if (ITrans) begin
            expOwn = 2'b01;
            streak = 0;
          end
          age = 0;
        end
        drive();
        quiet = (c >= 140);
        if (iDone || !ITrans) begin
          ITrans  = !quiet && ($urandom_range(0, 1) == 1);
          IAdress = W'($urandom_range(0, 63));
        end
        if (dDone || !DTrans) begin
          DTrans     = !quiet && ($urandom_range(0, 1) == 1);
          DAdress    = W'($urandom_range(0, 63));
          DReadWrite = 1'($urandom_range(0, 1));
          DWriteBus  = W'($urandom);
        end
      end
      samp();
      chk("rnd_drained", 32'({Owner, expOwn, ITrans, DTrans}), 32'd0);
      drive();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
